dest_hazard_unit: RTL
=====================

Name: dest_hazard_unit

Overview:
- Consumer side of the 5-bit write-destination select in the pipeline CPU.
- Tracks the destination register, regwrite flag and memread flag of every in-flight instruction through the EX, MEM and WB stages.
- Compares those entries against the source operands of the instruction in ID.
- Produces a one-cycle load-use stall and registered forwarding selects for the EX-stage operand muxes. It also keeps a saturating stall counter.

Parameters:
- REG_W, 5, register-number width; matches the destination mux output.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  source register A of the ID instruction.
- id_rt  in  REG_W  source register B of the ID instruction.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt.
- id_dest  in  REG_W  selected write destination (rt or rd) of the ID instruction.
- id_regwrite  in  1  instruction writes the register file.
- id_memread  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (branch taken).
- stall  out  1  hold PC and IF/ID, insert a bubble into EX; combinational.
- ex_fwd_a  out  2  operand A select for the instruction now in EX; registered.
- ex_fwd_b  out  2  operand B select for the instruction now in EX; registered.
- stall_cnt  out  CNT_W  number of cycles stall was asserted; saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ex/mem/wb valid bits, dests and flags cleared.
  - ex_fwd_a = ex_fwd_b = 2'b00, stall_cnt = 0.
  - stall therefore reads 0.
- Stage entry format: {valid, dest, regwrite, memread}. An entry counts as a "writer" only if valid & regwrite & dest != 0.
- Register 0 never causes a stall or a forward.
- stall = id_valid & !flush & EX is a writer & ex_memread & ((id_rs_used & id_rs == ex_dest) | (id_rt_used & id_rt == ex_dest)).
- Stage advance, every cycle:
  - wb <= mem; mem <= ex.
  - ex <= ID fields if id_valid & !stall & !flush; otherwise ex <= bubble (valid = 0).
- Forward select per operand, computed in ID and registered into ex_fwd_x at the same edge the instruction enters EX:
  - 2'b01 if the operand matches EX and EX is a non-load writer. The value comes from EX/MEM when this instruction reaches EX.
  - else 2'b10 if the operand matches MEM and MEM is a writer, load included. The value comes from MEM/WB.
  - else 2'b00: register file. The register file writes in the first half-cycle, so a match with WB needs no forward.
  - Nearest stage wins when both match.
  - An unused operand always gives 00.
  - On stall, flush or !id_valid, both selects are registered as 00.
- Load-use sequence:
  - Cycle N: stall = 1.
  - Cycle N+1: the load is in MEM, the dependent instruction re-evaluates, and the operand resolves to 10.
  - Exactly one stall cycle per load-use pair.
- Stall and flush in the same cycle: flush wins; stall is deasserted and a bubble enters EX.
- stall_cnt increments on every edge where stall = 1; it holds at all ones (2^CNT_W-1) and never wraps.
- Reset mid-operation: all in-flight entries are discarded immediately. After release, the first instruction sees no hazards.

Test Plan:
- Reset: rst_n=0 with random inputs -> stall=0, ex_fwd_a=ex_fwd_b=00, stall_cnt=0; outputs stay at these values one cycle after release with id_valid=0.
- EX forward: cycle 0 issue add dest=5 regwrite=1; cycle 1 issue rs=5 used -> stall=0; after the edge ex_fwd_a=01, ex_fwd_b=00.
- MEM forward and priority:
  - dest=7 at cycle 0, unrelated at cycle 1, rt=7 at cycle 2 -> ex_fwd_b=10.
  - Two writers to 7 back-to-back, then reader -> 01.
- Load-use:
  - Load dest=3 memread=1, then rs=3 -> stall=1 for exactly one cycle and the next EX holds a bubble (fwd 00).
  - The reader re-issues -> ex_fwd_a=10; stall_cnt=1.
- $0 and unused operands:
  - Writer dest=0, then reader rs=0 -> fwd 00, no stall.
  - Load dest=4, then reader rt=4 with rt_used=0 -> no stall.
- Flush and saturation:
  - Load-use pair with flush=1 in the stall cycle -> stall=0 and bubble enters EX.
  - With CNT_W=2, force 5 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/dest_hazard_unit_if.sv
// ID-stage hazard bus: the ID instruction's operand and destination fields going in,
// and the stall, forwarding selects and stall counter coming back.
interface dest_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] id_dest;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic             stall;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dest, id_regwrite, id_memread, flush,
        input  stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dest, id_regwrite, id_memread, flush,
        output stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );
endinterface

// File: rtl/dest_hazard_unit.sv
// Tracks in-flight destinations through EX/MEM/WB, raises the load-use stall and
// registers the EX operand forwarding selects; also counts stall cycles (saturating).
module dest_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    dest_hazard_unit_if.slave hz
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic             vld_p0, rw_p0, mr_p0;
    logic [REG_W-1:0] dest_p0;
    logic             vld_p1, rw_p1;
    logic [REG_W-1:0] dest_p1;
    logic             vld_p2, rw_p2;
    logic [REG_W-1:0] dest_p2;
    logic [1:0]       fwd_a_p0, fwd_b_p0;
    logic [CNT_W-1:0] cnt_q;

    logic             ex_w, mem_w, wb_w;
    logic             ld_hit, stall, issue;
    logic [1:0]       fwd_a_nxt, fwd_b_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A WB match resolves through the write-first register file, hence 00 there too.
    function automatic logic [1:0] fwd_sel(
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic             exw,
        input logic             exld,
        input logic [REG_W-1:0] exd,
        input logic             memw,
        input logic [REG_W-1:0] memd,
        input logic             wbw,
        input logic [REG_W-1:0] wbd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (!used)
            sel = FWD_RF;
        else if (exw && src == exd)
            sel = exld ? FWD_RF : FWD_EX;
        else if (memw && src == memd)
            sel = FWD_MEM;
        else if (wbw && src == wbd)
            sel = FWD_RF;
        return sel;
    endfunction

    // ID stage: hazard detection against the current EX/MEM/WB entries
    always_comb begin
        ex_w   = vld_p0 & rw_p0 & (dest_p0 != '0);
        mem_w  = vld_p1 & rw_p1 & (dest_p1 != '0);
        wb_w   = vld_p2 & rw_p2 & (dest_p2 != '0);
        ld_hit = (hz.id_rs_used & (hz.id_rs == dest_p0)) |
                 (hz.id_rt_used & (hz.id_rt == dest_p0));
        stall  = hz.id_valid & ~hz.flush & ex_w & mr_p0 & ld_hit;
        issue  = hz.id_valid & ~stall & ~hz.flush;
        fwd_a_nxt = fwd_sel(hz.id_rs_used, hz.id_rs, ex_w, mr_p0, dest_p0,
                            mem_w, dest_p1, wb_w, dest_p2);
        fwd_b_nxt = fwd_sel(hz.id_rt_used, hz.id_rt, ex_w, mr_p0, dest_p0,
                            mem_w, dest_p1, wb_w, dest_p2);
    end

    // ID -> EX -> MEM -> WB entry advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            rw_p0    <= 1'b0;
            mr_p0    <= 1'b0;
            dest_p0  <= '0;
            vld_p1   <= 1'b0;
            rw_p1    <= 1'b0;
            dest_p1  <= '0;
            vld_p2   <= 1'b0;
            rw_p2    <= 1'b0;
            dest_p2  <= '0;
            fwd_a_p0 <= FWD_RF;
            fwd_b_p0 <= FWD_RF;
            cnt_q    <= '0;
        end else begin
            vld_p2   <= vld_p1;
            rw_p2    <= rw_p1;
            dest_p2  <= dest_p1;
            vld_p1   <= vld_p0;
            rw_p1    <= rw_p0;
            dest_p1  <= dest_p0;
            vld_p0   <= issue;
            rw_p0    <= issue & hz.id_regwrite;
            mr_p0    <= issue & hz.id_memread;
            dest_p0  <= issue ? hz.id_dest : '0;
            fwd_a_p0 <= issue ? fwd_a_nxt : FWD_RF;
            fwd_b_p0 <= issue ? fwd_b_nxt : FWD_RF;
            if (stall)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    assign hz.stall     = stall;
    assign hz.ex_fwd_a  = fwd_a_p0;
    assign hz.ex_fwd_b  = fwd_b_p0;
    assign hz.stall_cnt = cnt_q;

endmodule
